// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, default sizes and latency saturation for the vector hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
  localparam int REG_ADDR_W_D = 4;
  localparam int NUM_SRC_D = 3;
  localparam int MAX_LAT_D = 8;
  function automatic int sat_lat(input int lat, input int max_lat);
    return lat > max_lat ? max_lat : lat;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown of in-flight multi-cycle results with busy lookups
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_D,
  parameter int NUM_LOOK = NUM_SRC_D + 1,
  parameter int MAX_LAT = MAX_LAT_D,
  localparam int CNT_W = $clog2(MAX_LAT + 1),
  localparam int NREG = 2 ** REG_ADDR_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue,
  input  logic [REG_ADDR_W-1:0]              issue_addr,
  input  logic [CNT_W-1:0]                   issue_lat,
  input  logic [NUM_LOOK-1:0][REG_ADDR_W-1:0] look_addr,
  output logic [NUM_LOOK-1:0]                look_busy,
  output logic [NREG-1:0]                    busy
);
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load;
  assign load = CNT_W'(sat_lat(int'(issue_lat), MAX_LAT));
  // load on issue, otherwise count nonzero entries down; register 0 stays empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else for (int r = 0; r < NREG; r++)
      cnt[r] <= r == 0 ? '0 : (issue && issue_addr == REG_ADDR_W'(r)) ? load : cnt[r] - CNT_W'(cnt[r] != '0);
  // occupancy vector and address lookups
  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = cnt[r] != '0;
    for (int i = 0; i < NUM_LOOK; i++) look_busy[i] = busy[look_addr[i]];
  end
endmodule

// File: rtl/vector_hazard_unit.sv
// vector_hazard_unit: forwarding selects, scoreboard-based stalls and branch flushes for the 5-stage vector pipe
module vector_hazard_unit import hazard_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_D,
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int MAX_LAT = MAX_LAT_D,
  localparam int CNT_W = $clog2(MAX_LAT + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] RAD,
  input  logic [REG_ADDR_W-1:0]             WA3D,
  input  logic                              RegWriteD,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] RAE,
  input  logic [REG_ADDR_W-1:0]             WA3E,
  input  logic [REG_ADDR_W-1:0]             WA3M,
  input  logic [REG_ADDR_W-1:0]             WA3W,
  input  logic                              ValidE,
  input  logic                              RegWriteE,
  input  logic                              MemtoRegE,
  input  logic                              MultiCycE,
  input  logic [CNT_W-1:0]                  LatE,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic                              PCSrcE,
  output logic [NUM_SRC-1:0][1:0]           ForwardE,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic [2**REG_ADDR_W-1:0]          BusyVec
);
  logic haz, issue;
  logic [NUM_SRC:0][REG_ADDR_W-1:0] look_addr;
  logic [NUM_SRC:0] look_busy;
  assign look_addr = {WA3D, RAD};
  // per-source bypass select, memory stage takes priority over writeback
  always_comb
    for (int i = 0; i < NUM_SRC; i++)
      ForwardE[i] = (RAE[i] != '0 && RegWriteM && RAE[i] == WA3M) ? FWD_M :
                    (RAE[i] != '0 && RegWriteW && RAE[i] == WA3W) ? FWD_W : FWD_RF;
  // decode hazard: load-use, multi-cycle producer in E, RAW or WAW on a busy register
  always_comb begin
    haz = RegWriteD && WA3D != '0 && look_busy[NUM_SRC];
    for (int i = 0; i < NUM_SRC; i++)
      haz = haz | (RAD[i] != '0 && (look_busy[i] || (ValidE && (MemtoRegE || MultiCycE) && RAD[i] == WA3E)));
  end
  assign StallF = haz & ~PCSrcE;
  assign StallD = haz & ~PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = haz | PCSrcE;
  assign issue = ValidE & RegWriteE & MultiCycE & (WA3E != '0) & (LatE != '0) & ~FlushE;
  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .NUM_LOOK(NUM_SRC + 1), .MAX_LAT(MAX_LAT)) u_sb (
    .clk(clk), .rst_n(rst_n), .issue(issue), .issue_addr(WA3E), .issue_lat(LatE),
    .look_addr(look_addr), .look_busy(look_busy), .busy(BusyVec)
  );
endmodule

// File: tb/tb_vector_hazard_unit.sv
// tb_vector_hazard_unit: directed and random checks against a ready-time reference model
module tb_vector_hazard_unit;
  localparam int AW = 4, NS = 3, ML = 8, CW = $clog2(ML + 1), NR = 2 ** AW;
  logic clk = 0, rst_n = 0;
  logic [NS-1:0][AW-1:0] RAD, RAE;
  logic [AW-1:0] WA3D, WA3E, WA3M, WA3W;
  logic RegWriteD, ValidE, RegWriteE, MemtoRegE, MultiCycE, RegWriteM, RegWriteW, PCSrcE;
  logic [CW-1:0] LatE;
  logic [NS-1:0][1:0] ForwardE;
  logic StallF, StallD, FlushD, FlushE;
  logic [NR-1:0] BusyVec;
  int total = 0, bad = 0, cyc = 0, n = 0;
  int ready_at [NR];
  logic exp_issue = 0;
  always #5 clk = ~clk;
  vector_hazard_unit #(.REG_ADDR_W(AW), .NUM_SRC(NS), .MAX_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .RAD(RAD), .WA3D(WA3D), .RegWriteD(RegWriteD), .RAE(RAE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MultiCycE(MultiCycE), .LatE(LatE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .ForwardE(ForwardE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .BusyVec(BusyVec)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit busy_m(input int r);
    return r != 0 && cyc < ready_at[r];
  endfunction
  task automatic clear_model();
    foreach (ready_at[r]) ready_at[r] = 0;
  endtask
  task automatic idle();
    RAD = '0; RAE = '0; WA3D = '0; WA3E = '0; WA3M = '0; WA3W = '0; LatE = '0;
    RegWriteD = 0; ValidE = 0; RegWriteE = 0; MemtoRegE = 0; MultiCycE = 0;
    RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
  endtask
  task automatic check_all();
    logic [NS-1:0][1:0] fwd;
    logic [NR-1:0] bv;
    logic haz;
    haz = RegWriteD && busy_m(int'(WA3D));
    for (int i = 0; i < NS; i++) begin
      fwd[i] = (RAE[i] != 0 && RegWriteM && RAE[i] == WA3M) ? 2'b10 :
               (RAE[i] != 0 && RegWriteW && RAE[i] == WA3W) ? 2'b01 : 2'b00;
      if (RAD[i] != 0 && ((ValidE && (MemtoRegE || MultiCycE) && RAD[i] == WA3E) || busy_m(int'(RAD[i])))) haz = 1;
    end
    for (int r = 0; r < NR; r++) bv[r] = busy_m(r);
    exp_issue = ValidE && RegWriteE && MultiCycE && WA3E != 0 && LatE != 0 && !(haz || PCSrcE);
    check("fwd", 32'(ForwardE), 32'(fwd));
    check("stallf", 32'(StallF), 32'(haz && !PCSrcE));
    check("stalld", 32'(StallD), 32'(haz && !PCSrcE));
    check("flushd", 32'(FlushD), 32'(PCSrcE));
    check("flushe", 32'(FlushE), 32'(haz || PCSrcE));
    check("busyvec", 32'(BusyVec), 32'(bv));
  endtask
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (exp_issue) ready_at[WA3E] = cyc + 1 + (int'(LatE) > ML ? ML : int'(LatE));
    cyc++;
    #1;
  endtask
  task automatic issue_to(input logic [AW-1:0] a, input logic [CW-1:0] l);
    idle();
    ValidE = 1; RegWriteE = 1; MultiCycE = 1; WA3E = a; LatE = l;
  endtask
  initial begin
    idle();
    clear_model();
    #2;
    check("rst_busy", 32'(BusyVec), 0);
    check("rst_stall", 32'(StallD), 0);
    check("rst_flush", 32'({FlushD, FlushE}), 0);
    check("rst_fwd", 32'(ForwardE), 0);
    @(posedge clk);
    #1 rst_n = 1;
    RAE[0] = 3; WA3M = 3; WA3W = 3; RegWriteM = 1; RegWriteW = 1;
    #1 check("fwd_m", 32'(ForwardE[0]), 2);
    RegWriteM = 0;
    #1 check("fwd_w", 32'(ForwardE[0]), 1);
    RAE[0] = 0;
    #1 check("fwd_rf", 32'(ForwardE[0]), 0);
    tick();
    idle();
    MemtoRegE = 1; ValidE = 1; WA3E = 5; RAD[1] = 5;
    #1 check("lu_stall", 32'({StallF, StallD, FlushE, FlushD}), 4'b1110);
    tick();
    idle();
    #1 check("lu_release", 32'({StallF, StallD, FlushE}), 0);
    issue_to(7, 4);
    tick();
    idle();
    RAD[2] = 7;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("mc_stall", 32'(StallD), 32'(k <= 4));
      check("mc_busy", 32'(BusyVec[7]), 32'(k <= 4));
      tick();
    end
    issue_to(9, 2);
    tick();
    idle();
    RegWriteD = 1; WA3D = 9;
    for (int k = 1; k <= 3; k++) begin
      #1 check("waw_stall", 32'(StallD), 32'(k <= 2));
      tick();
    end
    idle();
    MemtoRegE = 1; ValidE = 1; WA3E = 5; RAD[0] = 5; PCSrcE = 1;
    #1 check("br_flush", 32'({FlushD, FlushE}), 2'b11);
    check("br_nostall", 32'({StallF, StallD}), 0);
    tick();
    issue_to(4, 6);
    tick();
    idle();
    tick();
    #1 check("mid_busy", 32'(BusyVec[4]), 1);
    rst_n = 0;
    clear_model();
    #1 check("rst_async", 32'(BusyVec), 0);
    rst_n = 1;
    RAD[0] = 4;
    #1 check("post_rst", 32'(StallD), 0);
    tick();
    issue_to(5, 15);
    tick();
    idle();
    n = 0;
    repeat (12) begin
      #1 if (BusyVec[5]) n++;
      tick();
    end
    check("sat_len", 32'(n), 8);
    repeat (800) begin
      for (int i = 0; i < NS; i++) begin
        RAD[i] = AW'($urandom_range(0, 7));
        RAE[i] = AW'($urandom_range(0, 7));
      end
      WA3D = AW'($urandom_range(0, 7)); WA3E = AW'($urandom_range(0, 7));
      WA3M = AW'($urandom_range(0, 7)); WA3W = AW'($urandom_range(0, 7));
      RegWriteD = 1'($urandom); ValidE = 1'($urandom); RegWriteE = 1'($urandom);
      MemtoRegE = $urandom_range(0, 3) == 0; MultiCycE = $urandom_range(0, 1) == 0;
      LatE = CW'($urandom_range(0, 15)); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        clear_model();
        #1 rst_n = 1;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
